// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - single-cycle ALU with iterative shift-add multiplier and restoring divider
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             dbz,
    output logic             valid_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_LSL, OP_LSR, OP_NOT, OP_MUL, OP_DIV
    } op_t;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mreg;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    op_t              op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_dbz;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rs;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        op = OP_ADD;
        if (ALUOp == 3'b000) begin
            case (funct)
                6'd0:    op = OP_ADD;
                6'd1:    op = OP_SUB;
                6'd2:    op = OP_AND;
                6'd3:    op = OP_OR;
                6'd4:    op = OP_SLT;
                6'd5:    op = OP_LSL;
                6'd6:    op = OP_LSR;
                6'd7:    op = OP_NOT;
                6'd8:    op = OP_MUL;
                6'd9:    op = OP_DIV;
                default: op = OP_ADD;
            endcase
        end else begin
            case (ALUOp)
                3'b001:  op = OP_SUB;
                3'b010:  op = OP_SLT;
                default: op = OP_ADD;
            endcase
        end
    end

    // OP_DIV only reaches this path when b is zero; a nonzero divisor starts the iterative divider
    always_comb begin
        alu_hi  = '0;
        alu_dbz = 1'b0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LSL:  alu_res = a << b[SHW-1:0];
            OP_LSR:  alu_res = a >> b[SHW-1:0];
            OP_NOT:  alu_res = ~a;
            OP_DIV: begin
                alu_res = '1;
                alu_hi  = a;
                alu_dbz = 1'b1;
            end
            default: alu_res = a + b;
        endcase
    end

    // One iteration: acc_hi is the running partial product / remainder, acc_lo the multiplier / quotient
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mreg} : '0);
        div_rs   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_rs >= {1'b0, mreg});
        div_diff = div_rs[WIDTH-1:0] - mreg;
        if (state == DIV) begin
            step_hi = div_ge ? div_diff : div_rs[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mreg      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b0;
            dbz       <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                            state  <= (op == OP_MUL) ? MUL : DIV;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            mreg   <= b;
                            acc_hi <= '0;
                            acc_lo <= a;
                        end else begin
                            valid_out <= 1'b1;
                            result    <= alu_res;
                            hi        <= alu_hi;
                            zero      <= (alu_res == '0);
                            dbz       <= alu_dbz;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        valid_out <= 1'b1;
                        result    <= step_lo;
                        hi        <= step_hi;
                        zero      <= (step_lo == '0);
                        dbz       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed and randomized self-checking bench for alu_mdu
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        dbz;
    logic        valid_out;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] obs_res;
    logic [31:0] obs_hi;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
        .a(a), .b(b), .result(result), .hi(hi), .zero(zero), .dbz(dbz),
        .valid_out(valid_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the instruction means arithmetically, plus its documented latency
    function automatic void model(input logic [2:0] op, input logic [5:0] f,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic d, output int lat);
        int          kind;
        logic [63:0] p;
        logic [4:0]  sh;
        sh = y[4:0];
        if (op == 3'd0) kind = (f < 6'd10) ? int'(f) : 0;
        else if (op == 3'd1) kind = 1;
        else if (op == 3'd2) kind = 4;
        else kind = 0;
        h = 32'd0; d = 1'b0; lat = 1;
        case (kind)
            1: r = x - y;
            2: r = x & y;
            3: r = x | y;
            4: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5: r = x << sh;
            6: r = x >> sh;
            7: r = ~x;
            8: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0]; h = p[63:32]; lat = 33;
            end
            9: begin
                if (y == 32'd0) begin
                    r = 32'hFFFF_FFFF; h = x; d = 1'b1;
                end else begin
                    r = x / y; h = x % y; lat = 33;
                end
            end
            default: r = x + y;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y, input int inject);
        logic [31:0] er;
        logic [31:0] eh;
        logic        ed;
        int          lat;
        int          cyc;
        int          bcyc;
        model(op, f, x, y, er, eh, ed, lat);
        ALUOp = op; funct = f; a = x; b = y; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        cyc = 1; bcyc = 0;
        while (!valid_out && cyc < 100) begin
            if (busy) bcyc++;
            if (cyc == inject) begin
                valid_in = 1'b1; ALUOp = 3'd0; funct = 6'd0; a = 32'd1; b = 32'd1;
            end else begin
                valid_in = 1'b0;
            end
            step();
            cyc++;
        end
        valid_in = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_result"}, {32'd0, result}, {32'd0, er});
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, (er == 32'd0)});
        check({tag, "_dbz"}, {63'd0, dbz}, {63'd0, ed});
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(lat - 1));
        obs_res = result;
        obs_hi  = hi;
    endtask

    initial begin
        int vcount;
        logic [2:0]  rop;
        logic [5:0]  rf;
        logic [31:0] rx;
        logic [31:0] ry;

        rst = 1'b1; valid_in = 1'b1; ALUOp = 3'd0; funct = 6'd8; a = 32'd5; b = 32'd5;
        step();
        step();
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_dbz", {63'd0, dbz}, 64'd0);
        check("rst_valid", {63'd0, valid_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0; valid_in = 1'b0;
        step();
        check("rst_prio_valid", {63'd0, valid_out}, 64'd0);
        check("rst_prio_busy", {63'd0, busy}, 64'd0);

        run_op("sub", 3'd0, 6'd1, 32'd5, 32'd7, -1);
        check("sub_const", {32'd0, obs_res}, 64'hFFFF_FFFE);
        run_op("sub_zero", 3'd0, 6'd1, 32'd7, 32'd7, -1);
        run_op("mul", 3'd0, 6'd8, 32'hFFFF_FFFF, 32'd2, -1);
        check("mul_const", {obs_hi, obs_res}, 64'h1_FFFF_FFFE);
        run_op("div", 3'd0, 6'd9, 32'd100, 32'd7, 5);
        check("div_const", {obs_hi, obs_res}, {32'd2, 32'd14});
        run_op("mul_zero", 3'd0, 6'd8, 32'd0, 32'd123, -1);
        run_op("dbz", 3'd0, 6'd9, 32'd9, 32'd0, -1);
        check("dbz_const", {obs_hi, obs_res}, {32'd9, 32'hFFFF_FFFF});

        step(); step(); step();
        check("hold_valid", {63'd0, valid_out}, 64'd0);
        check("hold_result", {32'd0, result}, 64'hFFFF_FFFF);
        check("hold_dbz", {63'd0, dbz}, 64'd1);

        ALUOp = 3'd0; funct = 6'd8; a = 32'hDEAD_BEEF; b = 32'h0001_2345; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_flags", {60'd0, zero, dbz, valid_out, busy}, 64'd0);
        vcount = 0;
        repeat (40) begin
            step();
            if (valid_out || busy) vcount++;
        end
        check("abort_quiet", 64'(vcount), 64'd0);
        run_op("addi", 3'd3, 6'd0, 32'd3, 32'd4, -1);
        check("addi_const", {32'd0, obs_res}, 64'd7);

        run_op("br_sub", 3'd1, 6'd0, 32'h8000_0001, 32'd1, -1);
        check("br_sub_const", {32'd0, obs_res}, 64'h8000_0000);
        run_op("slti", 3'd2, 6'd0, 32'h8000_0001, 32'd1, -1);
        check("slti_const", {32'd0, obs_res}, 64'd1);
        run_op("addi2", 3'd3, 6'd0, 32'h8000_0001, 32'd1, -1);
        check("addi2_const", {32'd0, obs_res}, 64'h8000_0002);
        run_op("lsl", 3'd0, 6'd5, 32'h8000_0001, 32'd1, -1);
        check("lsl_const", {32'd0, obs_res}, 64'h0000_0002);
        run_op("lsr", 3'd0, 6'd6, 32'h8000_0001, 32'd1, -1);
        check("lsr_const", {32'd0, obs_res}, 64'h4000_0000);
        run_op("not", 3'd0, 6'd7, 32'h8000_0001, 32'd1, -1);
        check("not_const", {32'd0, obs_res}, 64'h7FFF_FFFE);
        run_op("op7_add", 3'd7, 6'd8, 32'd10, 32'd20, -1);
        run_op("f15_add", 3'd0, 6'd15, 32'hFFFF_FFFF, 32'd1, -1);
        run_op("lsl_wide", 3'd0, 6'd5, 32'd1, 32'h0000_003F, -1);

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rf  = 6'($urandom_range(0, 11));
            rx  = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            else if ($urandom_range(0, 1) == 1) ry = $urandom;
            else ry = 32'($urandom_range(1, 40));
            run_op("rnd", rop, rf, rx, ry, (i % 3 == 0) ? 7 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal values 8, 16, 32 or 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): number of shift-amount bits taken from b.

Interface
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 valid_in  input  1  operation request, qualified by busy=0.
REQ-006 ALUOp  input  3  class code: 000 R-type, 001 branch, 010 SLTI, 011 ADDI/LW/SW.
REQ-007 funct  input  6  R-type operation select; ignored unless ALUOp=000.
REQ-008 a, b  input  WIDTH each  operands; b also supplies the shift amount.
REQ-009 result  output  WIDTH  low result: ALU result, product low half or quotient.
REQ-010 hi  output  WIDTH  product high half or remainder; 0 for single-cycle ops.
REQ-011 zero  output  1  high when result==0; valid with valid_out.
REQ-012 dbz  output  1  divide-by-zero flag; valid with valid_out.
REQ-013 valid_out  output  1  one-cycle pulse marking result, hi, zero and dbz valid.
REQ-014 busy  output  1  high while a MUL or DIV is in progress.

Function
REQ-015 Decode for ALUOp=000 SHALL map funct 0..9 to ADD, SUB, AND, OR, SLT (signed), LSL, LSR, NOT (~a), MUL (unsigned), DIVU; any other funct decodes to ADD.
REQ-016 Decode SHALL map ALUOp 001 to SUB, 010 to SLT, 011 to ADD, and 100..111 to ADD.
REQ-017 Shifts SHALL use b[SHW-1:0] as the amount and fill vacated bits with zero.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH with no overflow flag; SLT result SHALL be 1 or 0.
REQ-019 A request SHALL be accepted on a rising edge with valid_in=1, busy=0 and rst=0; operands and decoded op SHALL be captured at that edge.
REQ-020 valid_in while busy=1 SHALL be ignored: not queued, no effect.
REQ-021 Single-cycle ops SHALL drive result, hi=0 and valid_out=1 in the cycle after acceptance (latency 1); busy SHALL stay 0.
REQ-022 FSM SHALL have states IDLE, MUL and DIV; only IDLE accepts requests.
REQ-023 IDLE->MUL on accepting MUL; IDLE->DIV on accepting DIVU with b!=0.
REQ-024 MUL and DIV SHALL each run an iteration counter from 0 to WIDTH-1, processing one bit per cycle (shift-add; restoring division), then return to IDLE.
REQ-025 MUL/DIV SHALL assert valid_out in the cycle after the WIDTH-th iteration edge, giving latency WIDTH+1 from acceptance.
REQ-026 busy SHALL rise in the cycle after acceptance and fall in the same cycle valid_out rises.
REQ-027 A new request MAY be accepted in the cycle valid_out is high.
REQ-028 MUL SHALL output the full 2*WIDTH-bit product as {hi,result}.
REQ-029 DIVU SHALL output quotient on result and remainder on hi.
REQ-030 DIVU with b=0 SHALL stay in IDLE and complete at latency 1 with result all ones, hi=a and dbz=1.
REQ-031 dbz SHALL be 0 for every other completion.
REQ-032 result, hi, zero and dbz SHALL hold their values until the next completion.

Reset
REQ-033 While rst=1 at a rising edge, result=0, hi=0, zero=0, dbz=0, valid_out=0, busy=0, the FSM SHALL enter IDLE and the counter SHALL clear to 0.
REQ-034 Reset during MUL/DIV SHALL abort the operation with no valid_out for it.
REQ-035 rst=1 SHALL take priority over a simultaneous valid_in.

Verification (WIDTH=32)
REQ-036 ALUOp=000, funct=1, a=5, b=7 -> next cycle valid_out=1, result=0xFFFFFFFE, zero=0.
REQ-037 ALUOp=000, funct=8, a=0xFFFFFFFF, b=2 -> busy high for 32 cycles; valid_out at cycle 33 with hi=1, result=0xFFFFFFFE.
REQ-038 ALUOp=000, funct=9, a=100, b=7 -> result=14, hi=2 at cycle 33; a second valid_in at cycle 5 is ignored.
REQ-039 DIVU with a=9, b=0 -> cycle 1: result=0xFFFFFFFF, hi=9, dbz=1, busy stays 0.
REQ-040 Start MUL, assert rst at cycle 10 -> all outputs 0, no valid_out; a following ALUOp=011, a=3, b=4 request -> result=7.
REQ-041 Sweep ALUOp 001/010/011 and funct 5/6/7 with a=0x80000001, b=1 -> SUB, SLT=1, ADD, LSL=0x00000002, LSR=0x40000000, NOT=0x7FFFFFFE.
